// File: rtl/bit_serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder slice.
package bit_serial_adder_pkg;

    // Controller states; encodings kept identical to the legacy defines.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_serial_adder_fa.sv
// Half-adder cell and the full-adder built from two of them.

module halfadder (
    output logic s,
    output logic c,
    input  logic x,
    input  logic y
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

module full_adder (
    output logic s,
    output logic co,
    input  logic x,
    input  logic y,
    input  logic ci
);

    logic s1;
    logic c1;
    logic c2;
    logic nc1;
    logic nc2;

    halfadder u_ha0 (.s(s1), .c(c1), .x(x),  .y(y));
    halfadder u_ha1 (.s(s),  .c(c2), .x(s1), .y(ci));

    // OR of the two half-adder carries in NAND-only form: ~(~c1 & ~c2).
    assign nc1 = ~(c1 & c1);
    assign nc2 = ~(c2 & c2);
    assign co  = ~(nc1 & nc2);

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle adder: operands loaded in parallel, summed LSB-first one bit
// per clock through a single full-adder cell and a carry flop.

module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .s  (fa_s),
        .co (fa_co),
        .x  (ra_q[0]),
        .y  (rb_q[0]),
        .ci (carry_q)
    );

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath updates; busy/done are computed one edge early
    // so they come straight out of flops.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                carry_d = fa_co;
                ra_d    = {1'b0, ra_q[WIDTH-1:1]};
                rb_d    = {1'b0, rb_q[WIDTH-1:1]};
                acc_d   = {fa_s, acc_q[WIDTH-1:1]};
                if (cnt_q == LAST) begin
                    sum_d   = {fa_s, acc_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench: drivers push expected results, monitors pop on done.
module tb_bit_serial_adder;

    typedef struct {
        logic [7:0] s;
        logic       c;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst8 = 1'b1;
    logic       rst4 = 1'b1;
    logic       start8 = 1'b0;
    logic       start4 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy8, done8, cout8;
    logic       busy4, done4, cout4;
    logic [7:0] sum8;
    logic [3:0] sum4;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t q8[$];
    exp_t q4[$];

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    bit_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s at t=%0t", name, $time);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] es, input logic ec);
        exp_t e;
        @(negedge clk);
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = ~a;
        b8 = ~b;
        e.s = es;
        e.c = ec;
        e.cyc = cyc + 8;
        q8.push_back(e);
    endtask

    task automatic wait_done8();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done8 && n < 30);
        if (!done8) fail("timeout_done8");
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        logic [4:0] full;
        @(negedge clk);
        a4 = a;
        b4 = b;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        a4 = ~a;
        b4 = ~b;
        full = {1'b0, a} + {1'b0, b};
        e.s = {4'h0, full[3:0]};
        e.c = full[4];
        e.cyc = cyc + 4;
        q4.push_back(e);
    endtask

    task automatic wait_done4();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done4 && n < 20);
        if (!done4) fail("timeout_done4");
    endtask

    // Monitor for the 8-bit instance: result, latency, busy length, hold.
    initial begin
        exp_t       e;
        logic [7:0] hold_s = '0;
        logic       hold_c = 1'b0;
        int         bcnt = 0;
        logic       prev_done = 1'b0;
        forever begin
            @(negedge clk or posedge rst8);
            if (rst8) begin
                q8.delete();
                hold_s = '0;
                hold_c = 1'b0;
                bcnt = 0;
                prev_done = 1'b0;
            end else begin
                if (done8) begin
                    chk("done8_single_pulse", int'(prev_done), 0);
                    if (q8.size() == 0) begin
                        fail("done8_unexpected");
                    end else begin
                        e = q8.pop_front();
                        chk("sum8", int'(sum8), int'(e.s));
                        chk("cout8", int'(cout8), int'(e.c));
                        chk("latency8", cyc, e.cyc);
                        chk("busy8_cycles", bcnt, 8);
                        hold_s = e.s;
                        hold_c = e.c;
                    end
                    bcnt = 0;
                end else if (busy8) begin
                    bcnt++;
                    chk("hold_sum8", int'(sum8), int'(hold_s));
                    chk("hold_cout8", int'(cout8), int'(hold_c));
                end else begin
                    bcnt = 0;
                end
                prev_done = done8;
            end
        end
    end

    // Monitor for the 4-bit instance: result and latency.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst4 && done4) begin
                if (q4.size() == 0) begin
                    fail("done4_unexpected");
                end else begin
                    e = q4.pop_front();
                    chk("sum4", int'(sum4), int'(e.s[3:0]));
                    chk("cout4", int'(cout4), int'(e.c));
                    chk("latency4", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    // Directed sequence on the 8-bit instance, then the 4-bit sweep.
    initial begin
        int unsigned off;
        int unsigned idx;
        logic [7:0]  pair;

        repeat (3) @(negedge clk);
        rst8 = 1'b0;
        rst4 = 1'b0;
        #1;
        chk("rst_busy", int'(busy8), 0);
        chk("rst_done", int'(done8), 0);
        chk("rst_sum", int'(sum8), 0);
        chk("rst_cout", int'(cout8), 0);

        // 0x35 + 0x4A, then 0x00 + 0x00 while 0x7F/0 must hold.
        issue8(8'h35, 8'h4A, 8'h7F, 1'b0);
        wait_done8();
        issue8(8'h00, 8'h00, 8'h00, 1'b0);
        wait_done8();

        // Overflow cases, second start in the first idle cycle.
        issue8(8'hFF, 8'h01, 8'h00, 1'b1);
        wait_done8();
        issue8(8'hFF, 8'hFF, 8'hFE, 1'b1);
        wait_done8();

        // Stray start mid-operation with changed operands must be ignored.
        issue8(8'h10, 8'h20, 8'h30, 1'b0);
        repeat (3) @(negedge clk);
        a8 = 8'hFF;
        b8 = 8'hFF;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8();
        repeat (12) @(negedge clk);

        // Reset during the 4th SHIFT cycle aborts with no done pulse.
        issue8(8'h80, 8'h80, 8'h00, 1'b1);
        repeat (4) @(negedge clk);
        #2;
        rst8 = 1'b1;
        #1;
        chk("abort_busy", int'(busy8), 0);
        chk("abort_done", int'(done8), 0);
        chk("abort_sum", int'(sum8), 0);
        chk("abort_cout", int'(cout8), 0);
        @(negedge clk);
        #2;
        rst8 = 1'b0;
        repeat (12) @(negedge clk);
        issue8(8'h01, 8'h02, 8'h03, 1'b0);
        wait_done8();

        // All 256 pairs on the 4-bit instance in a shuffled order.
        off = $urandom_range(0, 255);
        for (int unsigned i = 0; i < 256; i++) begin
            idx = (i * 37 + off) & 32'hFF;
            pair = idx[7:0];
            issue4(pair[7:4], pair[3:0]);
            wait_done4();
        end

        repeat (5) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
